text_cursor_locate: RTL and testbench

Generates the per-character text-cursor attribute bit, `m_att_data_b32`, for the VGA text path. It tracks the character address and the row-scan position across each frame. Each character-clock slot is compared against the CRTC cursor location and the cursor start/end scan lines. The block sits directly upstream of the cursor skew/blink stage, which consumes `m_att_data_b32` on the same `c_shift_ld` strobe.

---
 rtl/text_cursor_locate.sv | 114 +++++++++++
 tb/tb_text_cursor_locate.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_cursor_locate.sv
// Per-character text-cursor attribute for the VGA text path: tracks the
// character address and row scan through a frame and flags the cursor cell.
module text_cursor_locate #(
  parameter int ADDR_W = 16
) (
  input  logic              t_crt_clk,
  input  logic              h_reset,
  input  logic              c_shift_ld,
  input  logic              c_frame_start,
  input  logic              c_line_start,
  input  logic              c_line_end,
  input  logic              c_dis_en,
  input  logic [ADDR_W-1:0] c_start_addr,
  input  logic [ADDR_W-1:0] c_cur_loc,
  input  logic [4:0]        c_cr0a_b40,
  input  logic [4:0]        c_cr0b_b40,
  input  logic [4:0]        c_cr09_b40,
  input  logic [7:0]        c_cr13_offset,
  output logic              m_att_data_b32,
  output logic [4:0]        row_scan,
  output logic [ADDR_W-1:0] char_addr
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic              m_att_q, m_att_d;
  logic [4:0]        row_scan_q, row_scan_d;
  logic [ADDR_W-1:0] char_addr_q, char_addr_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] cur_loc_q, cur_loc_d;
  logic [4:0]        cur_start_q, cur_start_d;
  logic [4:0]        cur_end_q, cur_end_d;

  logic              in_win_s;
  logic [ADDR_W-1:0] slot_addr_s;
  logic [ADDR_W-1:0] row_pitch_s;

  // Next-state logic; strobe priority is frame start > line end > line start/slot.
  always_comb begin
    m_att_d     = m_att_q;
    row_scan_d  = row_scan_q;
    char_addr_d = char_addr_q;
    row_base_d  = row_base_q;
    cur_loc_d   = cur_loc_q;
    cur_start_d = cur_start_q;
    cur_end_d   = cur_end_q;

    // An inverted start/end pair yields an empty window, i.e. no cursor.
    in_win_s    = (row_scan_q >= cur_start_q) && (row_scan_q <= cur_end_q);
    row_pitch_s = ADDR_W'({c_cr13_offset, 1'b0});
    // A slot coinciding with line start uses the freshly reloaded row base.
    if (c_line_start) begin
      slot_addr_s = row_base_q;
    end else begin
      slot_addr_s = char_addr_q;
    end

    if (c_frame_start) begin
      row_base_d  = c_start_addr;
      char_addr_d = c_start_addr;
      row_scan_d  = 5'd0;
      cur_loc_d   = c_cur_loc;
      cur_start_d = c_cr0a_b40;
      cur_end_d   = c_cr0b_b40;
    end else if (c_line_end) begin
      if (row_scan_q == c_cr09_b40) begin
        row_scan_d = 5'd0;
        row_base_d = row_base_q + row_pitch_s;
      end else if (row_scan_q == 5'd31) begin
        row_scan_d = 5'd31;
      end else begin
        row_scan_d = row_scan_q + 5'd1;
      end
    end else begin
      char_addr_d = slot_addr_s;
      if (c_shift_ld) begin
        m_att_d = c_dis_en & (slot_addr_s == cur_loc_q) & in_win_s;
        if (c_dis_en) begin
          char_addr_d = slot_addr_s + ADDR_ONE;
        end else begin
          char_addr_d = slot_addr_s;
        end
      end else begin
        m_att_d = m_att_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge t_crt_clk) begin
    if (h_reset) begin
      m_att_q     <= 1'b0;
      row_scan_q  <= 5'd0;
      char_addr_q <= '0;
      row_base_q  <= '0;
      cur_loc_q   <= '0;
      cur_start_q <= 5'd0;
      cur_end_q   <= 5'd0;
    end else begin
      m_att_q     <= m_att_d;
      row_scan_q  <= row_scan_d;
      char_addr_q <= char_addr_d;
      row_base_q  <= row_base_d;
      cur_loc_q   <= cur_loc_d;
      cur_start_q <= cur_start_d;
      cur_end_q   <= cur_end_d;
    end
  end

  assign m_att_data_b32 = m_att_q;
  assign row_scan       = row_scan_q;
  assign char_addr      = char_addr_q;

endmodule

// File: tb/tb_text_cursor_locate.sv
// Directed bench for text_cursor_locate: cursor hits, latching, wrap,
// blanking, strobe priority, saturation and reset.
module tb_text_cursor_locate;

  logic        clk = 1'b0;
  logic        h_reset = 1'b0;
  logic        c_shift_ld = 1'b0;
  logic        c_frame_start = 1'b0;
  logic        c_line_start = 1'b0;
  logic        c_line_end = 1'b0;
  logic        c_dis_en = 1'b0;
  logic [15:0] c_start_addr = 16'h0000;
  logic [15:0] c_cur_loc = 16'h0000;
  logic [4:0]  c_cr0a_b40 = 5'd0;
  logic [4:0]  c_cr0b_b40 = 5'd0;
  logic [4:0]  c_cr09_b40 = 5'd15;
  logic [7:0]  c_cr13_offset = 8'd40;
  logic        m_att_data_b32;
  logic [4:0]  row_scan;
  logic [15:0] char_addr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  text_cursor_locate #(.ADDR_W(16)) dut (
    .t_crt_clk(clk), .h_reset(h_reset), .c_shift_ld(c_shift_ld),
    .c_frame_start(c_frame_start), .c_line_start(c_line_start),
    .c_line_end(c_line_end), .c_dis_en(c_dis_en), .c_start_addr(c_start_addr),
    .c_cur_loc(c_cur_loc), .c_cr0a_b40(c_cr0a_b40), .c_cr0b_b40(c_cr0b_b40),
    .c_cr09_b40(c_cr09_b40), .c_cr13_offset(c_cr13_offset),
    .m_att_data_b32(m_att_data_b32), .row_scan(row_scan), .char_addr(char_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    c_shift_ld = 1'b0; c_frame_start = 1'b0; c_line_start = 1'b0;
    c_line_end = 1'b0; h_reset = 1'b0;
  endtask

  task automatic do_frame(input logic [15:0] sa, input logic [15:0] loc,
                          input logic [4:0] st, input logic [4:0] en);
    c_start_addr = sa; c_cur_loc = loc; c_cr0a_b40 = st; c_cr0b_b40 = en;
    c_frame_start = 1'b1;
    tick();
  endtask

  task automatic do_line_start();
    c_line_start = 1'b1;
    tick();
  endtask

  task automatic do_line_end();
    c_line_end = 1'b1;
    tick();
  endtask

  task automatic do_slot(input logic de);
    c_shift_ld = 1'b1; c_dis_en = de;
    tick();
  endtask

  task automatic test_reset();
    h_reset = 1'b1;
    tick();
    total++;
    if (m_att_data_b32 !== 1'b0 || row_scan !== 5'd0 || char_addr !== 16'h0000) begin
      bad++;
      $display("FAIL reset: got att=%b row=%0d addr=%h want 0/0/0000",
               m_att_data_b32, row_scan, char_addr);
    end
  endtask

  task automatic test_basic_hit();
    logic exp;
    do_frame(16'h0000, 16'h0052, 5'd14, 5'd15);
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 16; s++) begin
        do_line_start();
        total++;
        if (char_addr !== 16'(r * 80) || row_scan !== 5'(s)) begin
          bad++;
          $display("FAIL basic_line r%0d s%0d: got addr=%h row=%0d want %h/%0d",
                   r, s, char_addr, row_scan, 16'(r * 80), s);
        end
        for (int c = 0; c < 4; c++) begin
          do_slot(1'b1);
          exp = (r == 1) && (c == 2) && (s >= 14);
          total++;
          if (m_att_data_b32 !== exp) begin
            bad++;
            $display("FAIL basic_hit r%0d s%0d c%0d: got %b want %b",
                     r, s, c, m_att_data_b32, exp);
          end
        end
        do_line_end();
      end
    end
  endtask

  task automatic test_inverted_window();
    do_frame(16'h0000, 16'h0052, 5'd10, 5'd5);
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 16; s++) begin
        do_line_start();
        for (int c = 0; c < 4; c++) begin
          do_slot(1'b1);
          total++;
          if (m_att_data_b32 !== 1'b0) begin
            bad++;
            $display("FAIL inverted r%0d s%0d c%0d: got %b want 0", r, s, c, m_att_data_b32);
          end
        end
        do_line_end();
      end
    end
  endtask

  task automatic test_midframe_write();
    logic exp;
    do_frame(16'h0000, 16'h0052, 5'd14, 5'd15);
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 16; s++) begin
        if (r == 0 && s == 3) c_cur_loc = 16'h0000;
        do_line_start();
        for (int c = 0; c < 4; c++) begin
          do_slot(1'b1);
          exp = (r == 1) && (c == 2) && (s >= 14);
          total++;
          if (m_att_data_b32 !== exp) begin
            bad++;
            $display("FAIL midwrite_old r%0d s%0d c%0d: got %b want %b",
                     r, s, c, m_att_data_b32, exp);
          end
        end
        do_line_end();
      end
    end
    do_frame(16'h0000, 16'h0000, 5'd14, 5'd15);
    for (int s = 0; s < 16; s++) begin
      do_line_start();
      for (int c = 0; c < 4; c++) begin
        do_slot(1'b1);
        exp = (c == 0) && (s >= 14);
        total++;
        if (m_att_data_b32 !== exp) begin
          bad++;
          $display("FAIL midwrite_new s%0d c%0d: got %b want %b", s, c, m_att_data_b32, exp);
        end
      end
      do_line_end();
    end
  endtask

  task automatic test_addr_wrap();
    logic [15:0] ea;
    do_frame(16'hFFFE, 16'h0001, 5'd0, 5'd15);
    do_line_start();
    total++;
    if (char_addr !== 16'hFFFE) begin
      bad++;
      $display("FAIL wrap_start: got %h want fffe", char_addr);
    end
    for (int i = 0; i < 4; i++) begin
      do_slot(1'b1);
      ea = 16'hFFFE + 16'(i + 1);
      total++;
      if (char_addr !== ea || m_att_data_b32 !== (i == 3)) begin
        bad++;
        $display("FAIL wrap_slot%0d: got addr=%h att=%b want %h/%b",
                 i, char_addr, m_att_data_b32, ea, (i == 3));
      end
    end
  endtask

  task automatic test_blanked();
    do_frame(16'h0000, 16'h0003, 5'd0, 5'd15);
    do_line_start();
    for (int i = 0; i < 3; i++) do_slot(1'b1);
    total++;
    if (char_addr !== 16'h0003 || m_att_data_b32 !== 1'b0) begin
      bad++;
      $display("FAIL blank_pre: got addr=%h att=%b want 0003/0", char_addr, m_att_data_b32);
    end
    for (int i = 0; i < 3; i++) begin
      do_slot(1'b0);
      total++;
      if (char_addr !== 16'h0003 || m_att_data_b32 !== 1'b0) begin
        bad++;
        $display("FAIL blank_slot%0d: got addr=%h att=%b want 0003/0",
                 i, char_addr, m_att_data_b32);
      end
    end
    do_slot(1'b1);
    total++;
    if (char_addr !== 16'h0004 || m_att_data_b32 !== 1'b1) begin
      bad++;
      $display("FAIL blank_post: got addr=%h att=%b want 0004/1", char_addr, m_att_data_b32);
    end
  endtask

  task automatic test_back_to_back();
    do_frame(16'h0052, 16'h0052, 5'd0, 5'd15);
    c_line_start = 1'b1; c_shift_ld = 1'b1; c_dis_en = 1'b1;
    tick();
    total++;
    if (char_addr !== 16'h0053 || m_att_data_b32 !== 1'b1) begin
      bad++;
      $display("FAIL linestart_slot: got addr=%h att=%b want 0053/1", char_addr, m_att_data_b32);
    end
  endtask

  task automatic test_saturate();
    do_frame(16'h0000, 16'h0000, 5'd0, 5'd15);
    c_cr09_b40 = 5'd2;
    do_line_end();
    do_line_end();
    c_cr09_b40 = 5'd1;
    for (int i = 0; i < 40; i++) do_line_end();
    total++;
    if (row_scan !== 5'd31) begin
      bad++;
      $display("FAIL saturate: got row=%0d want 31", row_scan);
    end
    do_frame(16'h0000, 16'h0000, 5'd0, 5'd15);
    total++;
    if (row_scan !== 5'd0) begin
      bad++;
      $display("FAIL saturate_frame: got row=%0d want 0", row_scan);
    end
    c_cr09_b40 = 5'd15;
  endtask

  task automatic test_simul_and_reset();
    do_frame(16'h0040, 16'h0041, 5'd0, 5'd15);
    for (int i = 0; i < 3; i++) do_line_end();
    c_cr09_b40 = 5'd3;
    c_frame_start = 1'b1; c_line_end = 1'b1;
    tick();
    total++;
    if (row_scan !== 5'd0) begin
      bad++;
      $display("FAIL simul_row: got row=%0d want 0", row_scan);
    end
    c_cr09_b40 = 5'd15;
    do_line_start();
    total++;
    if (char_addr !== 16'h0040) begin
      bad++;
      $display("FAIL simul_base: got addr=%h want 0040", char_addr);
    end
    do_slot(1'b1);
    do_slot(1'b1);
    total++;
    if (m_att_data_b32 !== 1'b1) begin
      bad++;
      $display("FAIL prereset_hit: got %b want 1", m_att_data_b32);
    end
    do_line_end();
    h_reset = 1'b1;
    tick();
    total++;
    if (m_att_data_b32 !== 1'b0 || row_scan !== 5'd0 || char_addr !== 16'h0000) begin
      bad++;
      $display("FAIL midline_reset: got att=%b row=%0d addr=%h want 0/0/0000",
               m_att_data_b32, row_scan, char_addr);
    end
    do_line_end();
    do_line_start();
    total++;
    if (row_scan !== 5'd1 || char_addr !== 16'h0000) begin
      bad++;
      $display("FAIL postreset_count: got row=%0d addr=%h want 1/0000", row_scan, char_addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_inverted_window();
    test_midframe_write();
    test_addr_wrap();
    test_blanked();
    test_back_to_back();
    test_saturate();
    test_simul_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
